// File: rtl/zeroriscy_defines.sv
// Shared definitions for the EX-stage multiply/divide sequencer: operation codes,
// sequencer states and the iteration count.
package zeroriscy_defines;

  localparam logic [1:0] MD_OP_MULL = 2'd0;
  localparam logic [1:0] MD_OP_MULH = 2'd1;
  localparam logic [1:0] MD_OP_DIV  = 2'd2;
  localparam logic [1:0] MD_OP_REM  = 2'd3;

  localparam int unsigned MD_ITERATIONS = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    LOOP = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_t;

  // MULL is sign-agnostic, so its operands are always taken as unsigned magnitudes
  function automatic logic md_operand_neg(input logic [1:0] op, input logic sgn, input logic msb);
    return (op != MD_OP_MULL) && sgn && msb;
  endfunction

endpackage

// File: rtl/zeroriscy_md_adder.sv
// 33-bit adder/subtractor shared by every arithmetic step of the md sequencer.
module zeroriscy_md_adder (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        inv_b,
  input  logic        cin,
  output logic [32:0] sum,
  output logic        cout
);

  logic [33:0] total_s;

  assign total_s = {1'b0, a} + {1'b0, (inv_b ? ~b : b)} + {33'd0, cin};
  assign sum     = total_s[32:0];
  assign cout    = total_s[33];

endmodule

// File: rtl/zeroriscy_md_seq.sv
// Iterative shift-add multiplier / restoring divider (36 cycles per operation).
// Optional macro MD_DIV0_FASTPATH_EN: DIV/REM by zero completes straight from ABS.
module zeroriscy_md_seq
  import zeroriscy_defines::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic [1:0]       op_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  md_state_t   state_r;
  logic [1:0]  op_r;
  logic        sa_r;
  logic        sb_r;
  logic        neg_r;
  logic [31:0] opa_r;
  logic [31:0] opb_r;
  logic [63:0] acc_r;
  logic [5:0]  cnt_r;
  logic [31:0] result_r;

  logic        mul_s;
  logic        accept_sb_s;
  logic        div0_fast_s;
  logic        neg_calc_s;
  logic [31:0] abs_a_s;
  logic [31:0] fix_word_s;
  logic [32:0] add_a_s;
  logic [32:0] add_b_s;
  logic        add_inv_s;
  logic        add_cin_s;
  logic [32:0] add_sum_s;
  logic        add_co_s;

  zeroriscy_md_adder u_adder (
    .a     (add_a_s),
    .b     (add_b_s),
    .inv_b (add_inv_s),
    .cin   (add_cin_s),
    .sum   (add_sum_s),
    .cout  (add_co_s)
  );

  assign mul_s       = (op_r == MD_OP_MULL) || (op_r == MD_OP_MULH);
  assign accept_sb_s = md_operand_neg(op_i, signed_mode_i[1], op_b_i[31]);
  assign abs_a_s     = sa_r ? add_sum_s[31:0] : opa_r;

`ifdef MD_DIV0_FASTPATH_EN
  assign div0_fast_s = !mul_s && (opb_r == 32'd0);
`else
  assign div0_fast_s = 1'b0;
`endif

  // Result sign and the word selected for output
  always_comb begin
    neg_calc_s = 1'b0;
    fix_word_s = acc_r[31:0];
    case (op_r)
      MD_OP_MULL: neg_calc_s = sa_r ^ sb_r;
      MD_OP_MULH: begin
        neg_calc_s = sa_r ^ sb_r;
        fix_word_s = acc_r[63:32];
      end
      MD_OP_DIV:  neg_calc_s = (sa_r ^ sb_r) && (opb_r != 32'd0);
      MD_OP_REM: begin
        neg_calc_s = sa_r;
        fix_word_s = acc_r[63:32];
      end
      default: neg_calc_s = 1'b0;
    endcase
  end

  // Adder operand steering; the divisor/multiplier magnitude is taken on the accept edge
  always_comb begin
    add_a_s   = 33'd0;
    add_b_s   = 33'd0;
    add_inv_s = 1'b0;
    add_cin_s = 1'b0;
    case (state_r)
      IDLE: begin
        add_b_s   = {1'b0, op_b_i};
        add_inv_s = 1'b1;
        add_cin_s = 1'b1;
      end
      ABS: begin
        add_b_s   = {1'b0, opa_r};
        add_inv_s = 1'b1;
        add_cin_s = 1'b1;
      end
      LOOP: begin
        if (mul_s) begin
          add_a_s = {1'b0, acc_r[63:32]};
          add_b_s = acc_r[0] ? {1'b0, opa_r} : 33'd0;
        end else begin
          add_a_s   = acc_r[63:31];
          add_b_s   = {1'b0, opb_r};
          add_inv_s = 1'b1;
          add_cin_s = 1'b1;
        end
      end
      FIX: begin
        // high word of a negated product only takes the +1 when the low word is zero
        add_b_s   = {1'b0, fix_word_s};
        add_inv_s = 1'b1;
        add_cin_s = (op_r == MD_OP_MULH) ? (acc_r[31:0] == 32'd0) : 1'b1;
      end
      default: begin
        add_a_s = 33'd0;
      end
    endcase
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= 2'd0;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      neg_r    <= 1'b0;
      opa_r    <= 32'd0;
      opb_r    <= 32'd0;
      acc_r    <= 64'd0;
      cnt_r    <= 6'd0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_i && !abort_i) begin
            op_r    <= op_i;
            sa_r    <= md_operand_neg(op_i, signed_mode_i[0], op_a_i[31]);
            sb_r    <= accept_sb_s;
            opa_r   <= op_a_i;
            opb_r   <= accept_sb_s ? add_sum_s[31:0] : op_b_i;
            state_r <= ABS;
          end else begin
            state_r <= IDLE;
          end
        end
        ABS: begin
          if (abort_i) begin
            state_r <= IDLE;
          end else if (div0_fast_s) begin
            result_r <= (op_r == MD_OP_DIV) ? 32'hFFFF_FFFF : opa_r;
            state_r  <= DONE;
          end else begin
            opa_r   <= abs_a_s;
            acc_r   <= mul_s ? {32'd0, opb_r} : {32'd0, abs_a_s};
            neg_r   <= neg_calc_s;
            cnt_r   <= 6'd0;
            state_r <= LOOP;
          end
        end
        LOOP: begin
          if (abort_i) begin
            state_r <= IDLE;
          end else begin
            if (mul_s) begin
              acc_r <= {add_sum_s, acc_r[31:1]};
            end else begin
              acc_r <= {(add_co_s ? add_sum_s[31:0] : acc_r[62:31]), acc_r[30:0], add_co_s};
            end
            cnt_r <= cnt_r + 6'd1;
            if (cnt_r == 6'(MD_ITERATIONS - 1)) begin
              state_r <= FIX;
            end
          end
        end
        FIX: begin
          if (abort_i) begin
            state_r <= IDLE;
          end else begin
            result_r <= neg_r ? add_sum_s[31:0] : fix_word_s;
            state_r  <= DONE;
          end
        end
        DONE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_r != IDLE);
  assign valid_o  = (state_r == DONE);
  assign result_o = result_r;

endmodule

// File: tb/tb_zeroriscy_md_seq.sv
// Self-checking bench for zeroriscy_md_seq: directed, randomized, back-to-back, abort and reset scenarios.
module tb_zeroriscy_md_seq;
  import zeroriscy_defines::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic [1:0]  op_i;
  logic [1:0]  signed_mode_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        abort_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int vectors = 0;
  int errors  = 0;

  localparam int OP_LAT = 35;
`ifdef MD_DIV0_FASTPATH_EN
  localparam int DIV0_LAT = 2;
`else
  localparam int DIV0_LAT = 35;
`endif

  always #5 clk = ~clk;

  zeroriscy_md_seq #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .op_i          (op_i),
    .signed_mode_i (signed_mode_i),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .abort_i       (abort_i),
    .busy_o        (busy_o),
    .valid_o       (valid_o),
    .result_o      (result_o)
  );

  // Architectural reference: RISC-V M-extension semantics in plain arithmetic
  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sm,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int ia, ib;
    ea = sm[0] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sm[1] ? {{32{b[31]}}, b} : {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      MD_OP_MULL: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      MD_OP_MULH: begin p = ea * eb; return p[63:32]; end
      MD_OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (sm == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
          return 32'(ia / ib);
        end
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (sm == 2'b11) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
          return 32'(ia % ib);
        end
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    return (op[1] && b == 32'd0) ? DIV0_LAT : OP_LAT;
  endfunction

  // Starts at a negedge in IDLE; returns at the negedge of the cycle after valid_o
  task automatic run_op(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input bit hold_req,
                        output logic [31:0] res, output int vcyc, output int nbusy);
    req_i = 1'b1; op_i = op; signed_mode_i = sm; op_a_i = a; op_b_i = b;
    vcyc = -1; nbusy = 0; res = 32'd0;
    @(posedge clk);
    for (int k = 1; k <= 60 && vcyc < 0; k++) begin
      @(negedge clk);
      if (!hold_req) req_i = 1'b0;
      if (busy_o) nbusy++;
      if (valid_o) begin vcyc = k; res = result_o; end
    end
    req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 1'b0; abort_i = 1'b0;
    op_i = 2'd0; signed_mode_i = 2'd0; op_a_i = 32'd0; op_b_i = 32'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [12] = '{MD_OP_MULL, MD_OP_MULH, MD_OP_MULH, MD_OP_MULH, MD_OP_DIV, MD_OP_REM,
                               MD_OP_DIV, MD_OP_REM, MD_OP_DIV, MD_OP_REM, MD_OP_DIV, MD_OP_REM};
    logic [1:0]  t_sm [12] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b11,
                               2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [31:0] t_a [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_e [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    int vcyc, nbusy, lat;
    for (int i = 0; i < 12; i++) begin
      run_op(t_op[i], t_sm[i], t_a[i], t_b[i], 1'b0, res, vcyc, nbusy);
      lat = exp_lat(t_op[i], t_b[i]);
      vectors++;
      if (res !== t_e[i]) begin errors++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, t_e[i]); end
      if (vcyc != lat) begin errors++; $display("FAIL directed_%0d_valid_cycle: got %0d expected %0d", i, vcyc, lat); end
      if (nbusy != lat) begin errors++; $display("FAIL directed_%0d_busy_cycles: got %0d expected %0d", i, nbusy, lat); end
      if (busy_o !== 1'b0) begin errors++; $display("FAIL directed_%0d_idle_after: got %b expected 0", i, busy_o); end
    end
  endtask

  task automatic test_random();
    logic [1:0] op, sm;
    logic [31:0] a, b, res, e;
    int vcyc, nbusy, sel;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      sm = op[1] ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : 2'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : (sel == 2) ? 32'hFFFF_FFFF : $urandom;
      e = ref_md(op, sm, a, b);
      run_op(op, sm, a, b, 1'b0, res, vcyc, nbusy);
      vectors++;
      if (res !== e) begin errors++; $display("FAIL random_%0d_result op=%0d sm=%b a=%h b=%h: got %h expected %h", i, op, sm, a, b, res, e); end
      if (vcyc != exp_lat(op, b)) begin errors++; $display("FAIL random_%0d_latency: got %0d expected %0d", i, vcyc, exp_lat(op, b)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, res;
    int vcyc, nbusy;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    run_op(MD_OP_MULL, 2'b00, a1, b1, 1'b1, res, vcyc, nbusy);
    vectors++;
    if (res !== ref_md(MD_OP_MULL, 2'b00, a1, b1)) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", res, ref_md(MD_OP_MULL, 2'b00, a1, b1)); end
    if (nbusy != OP_LAT) begin errors++; $display("FAIL b2b_held_req_busy: got %0d expected %0d", nbusy, OP_LAT); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_cycle36_idle: got %b expected 0", busy_o); end
    run_op(MD_OP_DIV, 2'b00, a2, b2, 1'b0, res, vcyc, nbusy);
    vectors++;
    if (res !== a2 / b2) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", res, a2 / b2); end
    if (vcyc != OP_LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", vcyc, OP_LAT); end
  endtask

  task automatic test_abort();
    int abort_at [2] = '{13, 34};
    logic [31:0] res, prev;
    int vcyc, nbusy;
    req_i = 1'b1; abort_i = 1'b1; op_i = MD_OP_MULL; op_a_i = 32'd3; op_b_i = 32'd5;
    @(negedge clk);
    req_i = 1'b0; abort_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle_blocks_req: got busy %b expected 0", busy_o); end
    for (int j = 0; j < 2; j++) begin
      prev = 32'd15 + 32'(j);
      run_op(MD_OP_MULL, 2'b00, 32'd3, prev / 32'd3 + ((j == 1) ? 32'd0 : 32'd0), 1'b0, res, vcyc, nbusy);
      prev = 32'd3 * (prev / 32'd3);
      req_i = 1'b1; op_i = MD_OP_DIV; signed_mode_i = 2'b11; op_a_i = $urandom; op_b_i = 32'd9;
      @(posedge clk);
      for (int k = 1; k <= abort_at[j]; k++) begin
        @(negedge clk);
        req_i = 1'b0;
      end
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_%0d_busy: got %b expected 0", j, busy_o); end
      if (valid_o !== 1'b0) begin errors++; $display("FAIL abort_%0d_valid: got %b expected 0", j, valid_o); end
      if (result_o !== prev) begin errors++; $display("FAIL abort_%0d_result_kept: got %h expected %h", j, result_o, prev); end
      run_op(MD_OP_REM, 2'b00, 32'd100, 32'd7, 1'b0, res, vcyc, nbusy);
      vectors++;
      if (res !== 32'd2) begin errors++; $display("FAIL abort_%0d_next_result: got %h expected %h", j, res, 32'd2); end
      if (vcyc != OP_LAT) begin errors++; $display("FAIL abort_%0d_next_latency: got %0d expected %0d", j, vcyc, OP_LAT); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int vcyc, nbusy;
    req_i = 1'b1; op_i = MD_OP_MULH; signed_mode_i = 2'b11; op_a_i = $urandom; op_b_i = $urandom;
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      req_i = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", valid_o); end
    if (result_o !== 32'd0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", result_o); end
    run_op(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd3, 1'b0, res, vcyc, nbusy);
    vectors++;
    if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rst_mid_next_result: got %h expected %h", res, 32'hFFFF_FFFE); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/zeroriscy_md_seq.md
# zeroriscy_md_seq

Iterative multiply/divide sequencer in the EX stage, beside the ALU. It consumes the MD_OP_* operation codes and operand values produced by the ID stage. Results are computed over a fixed number of cycles with a one-bit-per-cycle shift-add or restoring-division datapath. Completion is signalled back to the ID stage and the writeback mux, and the controller uses `busy_o` to stall.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  core clock
- `rst_n`  in  1  reset: synchronous, active-low
- `req_i`  in  1  start request; sampled only in IDLE
- `op_i`  in  2  MD_OP_MULL / MD_OP_MULH / MD_OP_DIV / MD_OP_REM
- `signed_mode_i`  in  2  bit0: operand A signed; bit1: operand B signed
- `op_a_i`  in  32  multiplicand / dividend
- `op_b_i`  in  32  multiplier / divisor
- `abort_i`  in  1  flush from controller; kills the operation in flight
- `busy_o`  out  1  high whenever state ≠ IDLE
- `valid_o`  out  1  one-cycle pulse; `result_o` is valid
- `result_o`  out  32  result; held from DONE until the next accept

## Operation
- Reset (`rst_n` low at an edge): state is IDLE; `busy_o`=0, `valid_o`=0, `result_o`=0; all datapath registers are cleared.
- IDLE: `req_i`=1 latches `op_i`, `signed_mode_i`, `op_a_i` and `op_b_i`, then goes to ABS.
- MULL ignores `signed_mode_i`, because the low word is sign-agnostic. DIV and REM use `signed_mode_i`=2'b11 for signed and 2'b00 for unsigned.
- ABS (1 cycle):
  - Replace each signed-negative operand with its two's-complement magnitude. 0x80000000 stays 0x80000000 as an unsigned magnitude.
  - Record `neg_res`. For MUL: sign(A) XOR sign(B). For DIV: same, forced to 0 if the divisor is 0. For REM: sign(A).
  - Clear the 6-bit iteration counter and go to LOOP.
- LOOP (32 cycles; counter runs 0..31, exits on 31):
  - MUL: 64-bit accumulator. Each cycle adds the multiplicand when the current multiplier LSB is set, then shifts right one bit.
  - DIV: restoring division. Each cycle shifts {rem, quo} left, trial-subtracts the divisor with 33-bit arithmetic, and keeps the difference and sets the quotient bit when it is non-negative.
  - Goes to FIX.
- FIX (1 cycle): if `neg_res`, negate the 64-bit product or the selected 32-bit quotient/remainder. Then select the output word:
  - MULL: product[31:0]
  - MULH: product[63:32]
  - DIV: quotient
  - REM: remainder
- DONE (1 cycle): `valid_o`=1, `result_o` is registered, then go to IDLE unconditionally.
- Divide by zero: quotient = 0xFFFFFFFF and remainder = dividend. Both fall out of the datapath naturally, given the `neg_res` rule above.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. This also falls out naturally.
- `abort_i`:
  - High in any state other than IDLE: next state is IDLE, no `valid_o`, `result_o` keeps its previous value.
  - High in IDLE: suppresses acceptance of `req_i` in that same cycle.
- `abort_i` in the DONE cycle: `valid_o` still pulses, because the result was already committed.

## Timing
- Accept edge is cycle 0.
- ABS is cycle 1, LOOP is cycles 2–33, FIX is cycle 34, DONE (`valid_o`=1) is cycle 35.
- `busy_o` is high in cycles 1–35.
- The earliest next accept is cycle 36 (back-to-back throughput is 1 operation per 36 cycles).
- `req_i` is ignored while `busy_o`=1; it does not queue.
- `busy_o` and `valid_o` are pure functions of the state register, with no combinational path from the inputs.

## Configuration
- `MD_DIV0_FASTPATH_EN` defined:
  - In ABS, a DIV/REM with divisor 0 skips LOOP and FIX. DONE is in cycle 2 with quotient 0xFFFFFFFF or remainder = original `op_a_i`.
  - All other operations are unchanged.
- Not defined: divide by zero takes the full 35 cycles and gives identical results.

## Structure
- Shared package `zeroriscy_defines`:
  - Reuse MD_OP_MULL/MULH/DIV/REM.
  - Add the `md_state_t` enum (IDLE, ABS, LOOP, FIX, DONE) and `MD_ITERATIONS` = 32.
- Sub-module `zeroriscy_md_adder`:
  - One 33-bit adder/subtractor shared by ABS negation, LOOP accumulate / trial-subtract, and FIX negation.
  - Only one of these is active per cycle.

## Test plan
- MULL 7 × 0xFFFFFFFD → 0xFFFFFFEB; `valid_o` only in cycle 35; `busy_o` high in cycles 1–35.
- MULH signed 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV signed 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100 / 7 → 14, REMU → 2.
- Divide by zero:
  - DIV signed 0xFFFFFFFB / 0 → 0xFFFFFFFF; REM → 0xFFFFFFFB.
  - Latency is 2 with `MD_DIV0_FASTPATH_EN`, 35 without.
- Overflow DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Abort and reset mid-operation:
  - `abort_i` in LOOP cycle 12 → IDLE next cycle, no `valid_o`, `result_o` unchanged. A `req_i` on the following cycle is accepted and completes normally.
  - Repeat with `rst_n` low instead → all outputs 0.
